pipeline_hazard_controller: RTL

- Sequences stall and flush for the five-stage pipeline registers, including the decode/execute register.
- Selects operand forwarding into execute.
- Freezes the pipeline while data memory is busy.
- Keeps saturating performance counters of stall and flush cycles.
- Sits beside the datapath. Its outputs drive the enable/clear of the fetch, decode/execute and execute/memory registers, and the execute operand muxes.

---
 rtl/pipeline_hazard_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for a five-stage pipeline: load-use bubbles, branch flushes,
// memory-busy freeze with a sticky timeout flag, operand forwarding selects and
// saturating stall/flush cycle counters. State updates on the falling clock edge.
module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned MEM_TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
    input  logic                      RegWriteE_i,
    input  logic                      RegWriteM_i,
    input  logic                      RegWriteW_i,
    input  logic                      ResultSrcE_i,
    input  logic                      PCSrcE_i,
    input  logic                      MemBusyM_i,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      StallE_o,
    output logic                      StallM_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic [1:0]                ForwardAE_o,
    output logic [1:0]                ForwardBE_o,
    output logic                      MemTimeout_o,
    output logic [CNT_WIDTH-1:0]      StallCycles_o,
    output logic [CNT_WIDTH-1:0]      FlushCycles_o
);

    localparam int unsigned TO_WIDTH = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StLuBubble, StMemWait} stateT;

    stateT                stateQ, stateD;
    logic [TO_WIDTH-1:0]  timeoutCntQ, timeoutCntD;
    logic                 memTimeoutQ, memTimeoutD;
    logic [CNT_WIDTH-1:0] stallCntQ, stallCntD;
    logic [CNT_WIDTH-1:0] flushCntQ, flushCntD;
    logic                 loadUseHazard;

    assign loadUseHazard = ResultSrcE_i & RegWriteE_i & (RdE_i != '0) &
                           ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));

    // Stall/flush sequencing. MEM_WAIT with busy low behaves exactly like RUN.
    always_comb begin
        stateD   = StRun;
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        if (!rst) begin
            if (MemBusyM_i) begin
                // Branch resolution is ignored here: E is frozen along with everything else.
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                stateD   = StMemWait;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (loadUseHazard && stateQ != StLuBubble) begin
                // Bubble lasts one cycle; the load has left E by the next cycle.
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
                stateD   = StLuBubble;
            end
        end
    end

    // Forwarding selects: M wins over W, x0 is never forwarded.
    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        if (!rst) begin
            if (RegWriteM_i && RdM_i != '0 && RdM_i == Rs1E_i)      ForwardAE_o = 2'b10;
            else if (RegWriteW_i && RdW_i != '0 && RdW_i == Rs1E_i) ForwardAE_o = 2'b01;
            if (RegWriteM_i && RdM_i != '0 && RdM_i == Rs2E_i)      ForwardBE_o = 2'b10;
            else if (RegWriteW_i && RdW_i != '0 && RdW_i == Rs2E_i) ForwardBE_o = 2'b01;
        end
    end

    // Memory-wait timeout tracking and saturating performance counters.
    always_comb begin
        timeoutCntD = '0;
        memTimeoutD = memTimeoutQ;
        if (stateQ == StMemWait && MemBusyM_i) begin
            timeoutCntD = (timeoutCntQ == TO_LIMIT) ? timeoutCntQ : timeoutCntQ + TO_WIDTH'(1);
            if (timeoutCntD == TO_LIMIT) memTimeoutD = 1'b1;
        end
        stallCntD = (StallF_o && stallCntQ != '1) ? stallCntQ + CNT_WIDTH'(1) : stallCntQ;
        flushCntD = (FlushE_o && flushCntQ != '1) ? flushCntQ + CNT_WIDTH'(1) : flushCntQ;
    end

    // State registers, updated on the same edge as the pipeline registers.
    always_ff @(negedge clk) begin
        if (rst) begin
            stateQ      <= StRun;
            timeoutCntQ <= '0;
            memTimeoutQ <= 1'b0;
            stallCntQ   <= '0;
            flushCntQ   <= '0;
        end else begin
            stateQ      <= stateD;
            timeoutCntQ <= timeoutCntD;
            memTimeoutQ <= memTimeoutD;
            stallCntQ   <= stallCntD;
            flushCntQ   <= flushCntD;
        end
    end

    assign MemTimeout_o  = memTimeoutQ;
    assign StallCycles_o = stallCntQ;
    assign FlushCycles_o = flushCntQ;

endmodule
